// File: rtl/pool_window_ctrl_pkg.sv
// pool_window_ctrl_pkg: shared states, pooling modes and default sizes for the pooling window sequencer
package pool_window_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_REG_NUM = 16;
  typedef enum logic [2:0] {IDLE, FILL, DRAIN, FLUSH, RESULT} state_t;
  typedef enum logic {POOL_MAX, POOL_AVG} pool_mode_t;
endpackage

// File: rtl/pool_window_ctrl_reduce.sv
// pool_reduce_unit: folds registered regfile read data into one signed max per window (or a scaled sum under AVG_POOL_EN)
module pool_reduce_unit
  import pool_window_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_W = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  rd_vld,
  input  logic                  first,
`ifdef AVG_POOL_EN
  input  pool_mode_t            mode,
  input  logic [$clog2(ACC_W)-1:0] shift,
`endif
  input  logic [DATA_WIDTH-1:0] rf_out,
  output logic [DATA_WIDTH-1:0] result
);
  logic signed [ACC_W-1:0] acc, acc_nx, smp;
  assign smp = ACC_W'($signed(rf_out));
  always_comb begin
`ifdef AVG_POOL_EN
    acc_nx = first ? smp : mode == POOL_AVG ? acc + smp : (smp > acc ? smp : acc);
`else
    acc_nx = (first || smp > acc) ? smp : acc;
`endif
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) acc <= '0;
    else if (rd_vld) acc <= acc_nx;
`ifdef AVG_POOL_EN
  assign result = mode == POOL_AVG ? DATA_WIDTH'(acc >>> shift) : DATA_WIDTH'(acc);
`else
  assign result = acc;
`endif
endmodule

// File: rtl/pool_window_ctrl.sv
// pool_window_ctrl: writes pixel pairs into the pooling regfile, then reads the window back and reduces it to one value.
// Define AVG_POOL_EN to add the pool_mode port and average pooling.
module pool_window_ctrl
  import pool_window_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int ADDR_W = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_W:0]       cfg_win_len,
`ifdef AVG_POOL_EN
  input  logic                  pool_mode,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  output logic                  rf_wr_ctrl,
  output logic [DATA_WIDTH-1:0] rf_in1,
  output logic [DATA_WIDTH-1:0] rf_in2,
  output logic [ADDR_W-1:0]     rf_adrs_in1,
  output logic [ADDR_W-1:0]     rf_adrs_in2,
  output logic [ADDR_W-1:0]     rf_adrs_out,
  input  logic [DATA_WIDTH-1:0] rf_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy
);
`ifdef AVG_POOL_EN
  localparam int ACC_W = DATA_WIDTH + ADDR_W;
  localparam int SH_W = $clog2(ACC_W);
`else
  localparam int ACC_W = DATA_WIDTH;
`endif
  localparam logic [ADDR_W:0] L_MAX = (ADDR_W+1)'(REG_NUM);
  localparam logic [ADDR_W:0] L_MIN = (ADDR_W+1)'(2);
  state_t state, state_nx;
  logic [ADDR_W:0] len_q, len_even, len_in, wptr, wptr_nx;
  logic [ADDR_W-1:0] rptr;
  logic [DATA_WIDTH-1:0] red_res;
  logic accept, go_drain, rd_issue, rd_last, rd_vld, rd_first;
  assign len_even = cfg_win_len & ~(ADDR_W+1)'(1);
`ifdef AVG_POOL_EN
  pool_mode_t mode_in, mode_q;
  logic [ADDR_W:0] len_clip;
  logic [SH_W-1:0] sh_in, sh_q;
  assign mode_in = pool_mode_t'(pool_mode);
  assign len_clip = len_even == '0 ? L_MIN : len_even > L_MAX ? L_MAX : len_even;
  // averaging divides by shifting, so the window is rounded down to a power of two
  always_comb begin
    sh_in = SH_W'(1);
    for (int i = 2; i <= ADDR_W; i++) if (len_clip[i]) sh_in = SH_W'(i);
    len_in = mode_in == POOL_AVG ? (ADDR_W+1)'(1) << sh_in : len_clip;
  end
`else
  assign len_in = len_even == '0 ? L_MIN : len_even > L_MAX ? L_MAX : len_even;
`endif
  assign accept = in_valid && in_ready;
  assign wptr_nx = wptr + (ADDR_W+1)'(2);
  assign go_drain = accept && wptr_nx == (state == IDLE ? len_in : len_q);
  assign rd_issue = state == DRAIN;
  assign rd_last = {1'b0, rptr} == len_q - (ADDR_W+1)'(1);
  always_comb begin
    state_nx = go_drain ? DRAIN
             : state == IDLE && accept ? FILL
             : state == DRAIN && rd_last ? FLUSH
             : state == FLUSH ? RESULT
             : state == RESULT && res_ready ? IDLE
             : state;
    in_ready = nrst && (state == IDLE || state == FILL);
    busy = state != IDLE;
    rf_wr_ctrl = in_valid && in_ready;
    rf_in1 = rf_wr_ctrl ? in_data1 : '0;
    rf_in2 = rf_wr_ctrl ? in_data2 : '0;
    rf_adrs_in1 = rf_wr_ctrl ? wptr[ADDR_W-1:0] : '0;
    rf_adrs_in2 = rf_wr_ctrl ? wptr[ADDR_W-1:0] + ADDR_W'(1) : '0;
    rf_adrs_out = rd_issue ? rptr : '0;
    res_valid = state == RESULT;
    res_data = res_valid ? red_res : '0;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      len_q <= '0;
      wptr <= '0;
      rptr <= '0;
      rd_vld <= 1'b0;
      rd_first <= 1'b0;
`ifdef AVG_POOL_EN
      mode_q <= POOL_MAX;
      sh_q <= '0;
`endif
    end else begin
      state <= state_nx;
      if (accept && state == IDLE) begin
        len_q <= len_in;
`ifdef AVG_POOL_EN
        mode_q <= mode_in;
        sh_q <= sh_in;
`endif
      end
      if (accept) wptr <= go_drain ? '0 : wptr_nx;
      if (rd_issue) rptr <= rd_last ? '0 : rptr + ADDR_W'(1);
      rd_vld <= rd_issue;
      rd_first <= rd_issue && rptr == '0;
    end
  pool_reduce_unit #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(ACC_W)) u_reduce (
    .clk(clk),
    .nrst(nrst),
    .rd_vld(rd_vld),
    .first(rd_first),
`ifdef AVG_POOL_EN
    .mode(mode_q),
    .shift(sh_q),
`endif
    .rf_out(rf_out),
    .result(red_res)
  );
endmodule

// File: tb/tb_pool_window_ctrl.sv
// tb_pool_window_ctrl: directed windows with a result scoreboard and a behavioural registered regfile
module tb_pool_window_ctrl;
  logic clk = 1'b0, nrst = 1'b0;
  logic [4:0] cfg_win_len = '0;
  logic in_valid = 1'b0, in_ready;
  logic [15:0] in_data1 = '0, in_data2 = '0;
  logic rf_wr_ctrl;
  logic [15:0] rf_in1, rf_in2, rf_out = '0, res_data;
  logic [3:0] rf_adrs_in1, rf_adrs_in2, rf_adrs_out;
  logic res_valid, res_ready = 1'b1, busy;
`ifdef AVG_POOL_EN
  logic pool_mode = 1'b0;
`endif
  int total = 0, bad = 0;
  int exp_q[$];
  logic [15:0] pix[16];
  logic [15:0] mem[16];
  always #5 clk = ~clk;
  pool_window_ctrl dut (
    .clk(clk),
    .nrst(nrst),
    .cfg_win_len(cfg_win_len),
`ifdef AVG_POOL_EN
    .pool_mode(pool_mode),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data1(in_data1),
    .in_data2(in_data2),
    .rf_wr_ctrl(rf_wr_ctrl),
    .rf_in1(rf_in1),
    .rf_in2(rf_in2),
    .rf_adrs_in1(rf_adrs_in1),
    .rf_adrs_in2(rf_adrs_in2),
    .rf_adrs_out(rf_adrs_out),
    .rf_out(rf_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .busy(busy)
  );
  always @(posedge clk) begin
    if (rf_wr_ctrl) begin
      mem[rf_adrs_in1] <= rf_in1;
      mem[rf_adrs_in2] <= rf_in2;
    end
    rf_out <= mem[rf_adrs_out];
  end
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res_unexpected act=%0d exp=none", int'($signed(res_data)));
      end else chk("res_data", int'($signed(res_data)), exp_q.pop_front());
    end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [15:0] a, input logic [15:0] b, input int adr);
    in_valid = 1'b1;
    in_data1 = a;
    in_data2 = b;
    #1;
    chk("in_ready", int'(in_ready), 1);
    chk("wr_ctrl", int'(rf_wr_ctrl), 1);
    chk("wr_adr1", int'(rf_adrs_in1), adr);
    chk("wr_adr2", int'(rf_adrs_in2), adr + 1);
    chk("wr_d1", int'(rf_in1), int'(a));
    chk("wr_d2", int'(rf_in2), int'(b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
  endtask
  task automatic set4(input int a, input int b, input int c, input int d);
    pix[0] = 16'(a);
    pix[1] = 16'(b);
    pix[2] = 16'(c);
    pix[3] = 16'(d);
  endtask
  task automatic run_window(input int cfg, input int l, input bit gap, input int stall, input int expv);
    int lat;
    cfg_win_len = 5'(cfg);
    res_ready = (stall == 0);
    exp_q.push_back(expv);
    for (int b = 0; b < l / 2; b++) begin
      beat(pix[2*b], pix[2*b+1], 2 * b);
      if (gap && b < l / 2 - 1) begin
        chk("gap_ready", int'(in_ready), 1);
        chk("gap_busy", int'(busy), 1);
        cyc;
      end
    end
    lat = -1;
    for (int k = 0; k < 64; k++) begin
      if (k < l) chk("rd_adr", int'(rf_adrs_out), k);
      chk("drain_ready", int'(in_ready), 0);
      cyc;
      if (res_valid) begin
        lat = k + 1;
        break;
      end
    end
    chk("latency", lat, l + 1);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_data1 = 16'h1234;
      in_data2 = 16'h7fff;
      #1;
      chk("stall_valid", int'(res_valid), 1);
      chk("stall_data", int'($signed(res_data)), expv);
      chk("stall_ready", int'(in_ready), 0);
      chk("stall_wr", int'(rf_wr_ctrl), 0);
      cyc;
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    cyc;
    chk("idle_busy", int'(busy), 0);
    chk("idle_ready", int'(in_ready), 1);
  endtask
  initial begin
    #1;
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_rdadr", int'(rf_adrs_out), 0);
    #11;
    nrst = 1'b1;
    #1;
    chk("rel_ready", int'(in_ready), 1);
    cyc;
    set4(3, -7, 12, 5);
    run_window(4, 4, 1'b0, 0, 12);
    set4(-4, -9, 0, 0);
    run_window(2, 2, 1'b0, 0, -4);
    for (int i = 0; i < 15; i++) pix[i] = 16'(i * 100 - 800);
    pix[15] = 16'h7fff;
    run_window(16, 16, 1'b1, 0, 32767);
    set4(1, 2, -3, 0);
    run_window(4, 4, 1'b0, 10, 2);
    set4(-20, -30, -10, -40);
    run_window(5, 4, 1'b0, 0, -10);
    cfg_win_len = 5'd4;
    beat(16'd10, 16'd20, 0);
    beat(16'd30, 16'd40, 2);
    cyc;
    cyc;
    in_valid = 1'b1;
    in_data1 = 16'd5;
    nrst = 1'b0;
    #1;
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wr", int'(rf_wr_ctrl), 0);
    chk("mid_rst_d1", int'(rf_in1), 0);
    chk("mid_rst_adr1", int'(rf_adrs_in1), 0);
    chk("mid_rst_adr2", int'(rf_adrs_in2), 0);
    chk("mid_rst_rdadr", int'(rf_adrs_out), 0);
    chk("mid_rst_valid", int'(res_valid), 0);
    chk("mid_rst_data", int'(res_data), 0);
    in_valid = 1'b0;
    cyc;
    nrst = 1'b1;
    #1;
    chk("mid_rel_ready", int'(in_ready), 1);
    cyc;
    set4(7, 100, -50, 99);
    run_window(4, 4, 1'b0, 0, 100);
    set4(5, 6, 0, 0);
    run_window(0, 2, 1'b0, 0, 6);
    for (int i = 0; i < 16; i++) pix[i] = 16'(1000 - 7 * i);
    run_window(31, 16, 1'b0, 0, 1000);
`ifdef AVG_POOL_EN
    pool_mode = 1'b1;
    set4(2, 4, 6, -4);
    run_window(4, 4, 1'b0, 0, 2);
    set4(8, 8, 8, 9);
    run_window(6, 4, 1'b0, 0, 8);
    pool_mode = 1'b0;
`endif
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
